// File: rtl/wifi_rx_pkg.sv
// Shared definitions for the WiFi UART receive peripheral: register map, status bits, FSM encoding.
package wifi_rx_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_CTRL   = 4'h4;

  localparam int STAT_OVERRUN = 15;
  localparam int STAT_FRAME   = 14;
  localparam int STAT_PARITY  = 13;
  localparam int STAT_FULL    = 9;
  localparam int STAT_EMPTY   = 8;

  localparam int CTRL_CLR_ERR = 0;
  localparam int CTRL_FLUSH   = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/wifi_rx_fifo.sv
// Byte-wide receive FIFO; flush beats a same-cycle push, push while full only lands with a pop.
module wifi_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty,
  output logic [6:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = 7'(r_count);
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // When full, the write slot equals the head being popped; the head is read before this edge.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/peripheral_wifi_rx.sv
// WiFi module UART receiver with FIFO and J1 register interface.
// Define WIFI_RX_PARITY_EN for 8E1 framing (even parity); default build is 8N1.
//   state    | meaning
//   S_IDLE   | waiting for falling edge on synchronized rx
//   S_START  | half-bit wait, confirm start bit
//   S_DATA   | sampling 8 data bits LSB first
//   S_PARITY | sampling even parity bit (parity build only)
//   S_STOP   | sampling stop bit, push or flag error
module peripheral_wifi_rx
  import wifi_rx_pkg::*;
#(
  parameter int clkFreq    = 50000000,
  parameter int baudRate   = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int DIV = clkFreq / baudRate;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_rx_d;
  rx_state_t     r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_push;
  logic          r_ferr_set;
  logic          r_overrun;
  logic          r_frame_err;
  logic          w_perr;
  logic          w_rx;
  logic          w_fall;
  logic          w_tick;
  logic          w_pop;
  logic          w_flush;
  logic          w_clr;
  logic          w_ovr_set;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [6:0]    w_count;
  logic [15:0]   w_status;
  logic          w_unused_din;

`ifdef WIFI_RX_PARITY_EN
  logic r_par_ok;
  logic r_perr_set;
  logic r_parity_err;
`endif

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_rx_d <= w_rx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_push     <= 1'b0;
      r_ferr_set <= 1'b0;
`ifdef WIFI_RX_PARITY_EN
      r_par_ok   <= 1'b0;
      r_perr_set <= 1'b0;
`endif
    end else begin
      r_push     <= 1'b0;
      r_ferr_set <= 1'b0;
`ifdef WIFI_RX_PARITY_EN
      r_perr_set <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_baud_cnt <= HALF_M1;
          end
        end
        S_START: begin
          if (!w_tick) r_baud_cnt <= r_baud_cnt - 1'b1;
          else if (w_rx) r_state <= S_IDLE;
          else begin
            r_state    <= S_DATA;
            r_baud_cnt <= DIV_M1;
            r_bit_cnt  <= '0;
          end
        end
        S_DATA: begin
          if (!w_tick) r_baud_cnt <= r_baud_cnt - 1'b1;
          else begin
            r_shift    <= {w_rx, r_shift[7:1]};
            r_baud_cnt <= DIV_M1;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
`ifdef WIFI_RX_PARITY_EN
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
`else
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
`endif
          end
        end
`ifdef WIFI_RX_PARITY_EN
        S_PARITY: begin
          if (!w_tick) r_baud_cnt <= r_baud_cnt - 1'b1;
          else begin
            r_par_ok   <= (w_rx == ^r_shift);
            r_baud_cnt <= DIV_M1;
            r_state    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!w_tick) r_baud_cnt <= r_baud_cnt - 1'b1;
          else begin
            r_state <= S_IDLE;
            if (!w_rx) r_ferr_set <= 1'b1;
`ifdef WIFI_RX_PARITY_EN
            else if (!r_par_ok) r_perr_set <= 1'b1;
`endif
            else r_push <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop     = cs & rd & (addr == REG_DATA);
  assign w_flush   = cs & wr & (addr == REG_CTRL) & d_in[CTRL_FLUSH];
  assign w_clr     = cs & wr & (addr == REG_CTRL) & d_in[CTRL_CLR_ERR];
  assign w_ovr_set = r_push & w_full & ~(w_pop & ~w_empty) & ~w_flush;
  assign w_unused_din = ^d_in[15:2];

  wifi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (r_shift),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Set terms are OR-ed after the clear so a same-cycle error survives a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= w_ovr_set  | (r_overrun   & ~w_clr);
      r_frame_err <= r_ferr_set | (r_frame_err & ~w_clr);
    end
  end

`ifdef WIFI_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_parity_err <= 1'b0;
    else      r_parity_err <= r_perr_set | (r_parity_err & ~w_clr);
  end
  assign w_perr = r_parity_err;
`else
  assign w_perr = 1'b0;
`endif

  always_comb begin
    w_status               = '0;
    w_status[STAT_OVERRUN] = r_overrun;
    w_status[STAT_FRAME]   = r_frame_err;
    w_status[STAT_PARITY]  = w_perr;
    w_status[STAT_FULL]    = w_full;
    w_status[STAT_EMPTY]   = w_empty;
    w_status[6:0]          = w_count;
  end

  always_comb begin
    d_out = '0;
    if (cs) begin
      case (addr)
        REG_DATA:   if (!w_empty) d_out = {8'h00, w_head};
        REG_STATUS: d_out = w_status;
        default:    d_out = '0;
      endcase
    end
  end

  assign rx_irq = ~w_empty | r_overrun | r_frame_err | w_perr;

endmodule

// File: doc/peripheral_wifi_rx.md
PERIPHERAL_WIFI_RX -- requirements
Module: peripheral_wifi_rx

Interface
REQ-001 SHALL have parameter clkFreq, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baudRate, default 115200, serial bit rate from the WiFi module.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two, 4..64).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d_in  input  16  J1 write data.
REQ-007 cs  input  1  chip select from the SoC address decoder.
REQ-008 addr  input  4  register offset (j1_io_addr[3:0]).
REQ-009 rd  input  1  J1 read strobe, one cycle.
REQ-010 wr  input  1  J1 write strobe, one cycle.
REQ-011 d_out  output  16  read data to the SoC read mux.
REQ-012 rx  input  1  asynchronous serial line from the WiFi module (idle high).
REQ-013 rx_irq  output  1  high while FIFO non-empty or any sticky error set.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer, reset value 1, before any use.
REQ-015 SHALL use bit period DIV = clkFreq/baudRate (integer division; 434 at defaults).
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP; IDLE->START on synchronized rx falling edge.
REQ-017 START SHALL sample at DIV/2 cycles; rx=1 returns to IDLE (glitch, no flags), rx=0 enters DATA.
REQ-018 DATA SHALL sample 8 bits, LSB first, each DIV cycles after the previous sample.
REQ-019 STOP SHALL sample DIV cycles after the last data bit; rx=1 pushes the byte, rx=0 discards it and sets frame_err; FSM then returns to IDLE.
REQ-020 Byte SHALL be written into FIFO on the cycle following the stop sample.
REQ-021 Push while full and no same-cycle pop SHALL drop the byte and set overrun; FIFO contents unchanged.
REQ-022 Pop occurs at the clock edge where cs&rd&addr==4'h0 and FIFO non-empty; pop on empty SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL both succeed, count unchanged, including when full.
REQ-024 d_out SHALL be combinational while cs=1: addr 0 -> {8'h00, FIFO head} (0x0000 if empty); addr 2 -> status; other -> 0x0000; cs=0 -> 0x0000.
REQ-025 Status word: [15]=overrun, [14]=frame_err, [13]=parity_err, [9]=full, [8]=empty, [6:0]=count.
REQ-026 Write cs&wr&addr==4'h4: d_in[0]=1 clears sticky errors, d_in[1]=1 flushes FIFO; same-cycle push with flush SHALL be discarded.
REQ-027 Sticky error set and clear in same cycle: set SHALL win.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-029 Reset SHALL force FSM=IDLE, FIFO empty, count=0, all sticky errors 0, rx_irq=0, synchronizer=1, baud and bit counters 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, reception resumes only at the next falling edge.

Configuration
REQ-031 Macro WIFI_RX_PARITY_EN defined: frame is 8E1; parity bit sampled DIV after bit 7 and before STOP; mismatch discards the byte and sets parity_err.
REQ-032 Macro absent: frame is 8N1, no parity sampling, status[13] reads 0.

Structure
REQ-033 Package wifi_rx_pkg SHALL hold register offsets (0x0, 0x2, 0x4), status bit positions, and the FSM state encoding.
REQ-034 FIFO SHALL be a sub-module wifi_rx_fifo (parameter DEPTH, width 8, push/pop/flush, full/empty/count).

Verification
REQ-035 Send 0x41 8N1 at 115200 -> status empty=0, count=1; read addr 0 -> 0x0041; status empty=1.
REQ-036 Send 17 bytes 0x00..0x10 without reads -> count=16, full=1, overrun=1; reads return 0x00..0x0F in order.
REQ-037 Send 0x55 with stop bit forced 0 -> FIFO empty, frame_err=1, rx_irq=1; write 0x0001 to addr 4 -> status 0x0100, rx_irq=0.
REQ-038 rx low pulse of 100 cycles while idle -> no byte, no error flags, FSM back to IDLE.
REQ-039 Assert rst during bit 4 of a frame, release, send 0xA5 -> exactly one entry, value 0xA5.
REQ-040 With WIFI_RX_PARITY_EN, send 0x03 with parity bit 1 -> byte discarded, parity_err=1; parity bit 0 -> 0x0003 read.
